mandelbrot_scheduler: RTL and testbench
=======================================

# mandelbrot_scheduler

Frame-level sequencer for the `mandelbrotetron` iteration engine. It walks a rectangular grid of complex points, issues one `start` per pixel with the pixel's `c` value, waits for the engine's `valid`, and hands each result to a downstream framebuffer writer over a valid/ready handshake. It sits between the configuration registers (origin and step) and the pixel store, and is the only driver of the engine's `start` and `c` inputs.

## Interface
- `FIXED_POINT_WIDTH`, 16, width of signed fixed-point `c`, origin and step values; must match the engine.
- `MAX_ITER`, 256, engine iteration limit; sets the iteration field width `IW = $clog2(MAX_ITER)`.
- `H_RES`, 160, pixels per row (≥2).
- `V_RES`, 120, rows per frame (≥2).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `frame_start`  in  1  one-cycle request to render a frame; accepted only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE, no `frame_done`.
- `x_origin`, `y_origin`  in  FIXED_POINT_WIDTH  signed `c` of pixel (0,0); sampled on an accepted `frame_start`.
- `step`  in  FIXED_POINT_WIDTH  signed per-pixel increment; sampled with the origins.
- `eng_start`  out  1  start pulse to the engine.
- `eng_c_real`, `eng_c_imag`  out  FIXED_POINT_WIDTH  current pixel's `c`.
- `eng_valid`  in  1  engine result valid.
- `eng_is_mandelbrot`  in  1  engine in-set flag.
- `eng_iterations`  in  IW  engine iteration count.
- `pix_valid`  out  1  result available.
- `pix_ready`  in  1  downstream accepts.
- `pix_x`  out  $clog2(H_RES)  column.
- `pix_y`  out  $clog2(V_RES)  row.
- `pix_iter`  out  IW  latched iteration count.
- `pix_in_set`  out  1  latched in-set flag.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse after the last pixel's handshake.
- `timeout_err`  out  1  sticky watchdog flag (see Configuration).

## Operation
- States: IDLE, ISSUE, WAIT, WRITE.
- IDLE: `frame_start` latches `x_origin`, `y_origin` and `step`, clears `x`, `y`, loads `c_re=x_origin`, `c_im=y_origin`, then transitions to ISSUE.
- ISSUE: `eng_start=1` for exactly this cycle, then WAIT.
- WAIT: first cycle ignores `eng_valid`, which can be stale from the previous pixel. From the second cycle on, `eng_valid=1` latches `eng_iterations` and `eng_is_mandelbrot` into `pix_iter`/`pix_in_set` and moves to WRITE.
- WRITE: `pix_valid=1`. Outputs hold stable until `pix_ready`. On handshake:
  - Not last column: `x++`, `c_re += step`.
  - Last column, not last row: `x=0`, `y++`, `c_re=x_origin`, `c_im -= step` (imaginary axis decreases downward).
  - Both ISSUE next.
  - Last pixel (`x=H_RES-1`, `y=V_RES-1`): `frame_done` pulses the following cycle, state goes to IDLE.
- Arithmetic: `c_re`/`c_im` are two's-complement, FIXED_POINT_WIDTH bits, wrap modulo 2^W with no saturation.
- `eng_c_real`/`eng_c_imag` are driven directly from `c_re`/`c_im` and are stable from ISSUE through WRITE.
- `frame_start` outside IDLE is ignored. `abort` has priority over all transitions except `rst`. Origin/step changes outside IDLE have no effect.
- `abort` in WRITE drops `pix_valid` immediately next cycle; the pixel is lost.

## Timing
- Reset values: state IDLE; `eng_start`, `pix_valid`, `busy`, `frame_done`, `timeout_err` = 0. All other outputs (pix_x, pix_y, pix_iter, pix_in_set, eng_c_real, eng_c_imag) = 0.
- `frame_start` at cycle T: `busy` and `eng_start` high at T+1.
- Per pixel: 1 ISSUE + (engine latency, ≥1 WAIT) + ≥1 WRITE cycle. Next `eng_start` comes the cycle after the `pix_ready` handshake.
- `frame_done` is high for exactly one cycle, coincident with the first IDLE cycle; `busy` is 0 in that cycle.
- `rst` mid-frame: everything returns to reset values at the next edge, with no `frame_done`.
- `abort` and `frame_start` in the same IDLE cycle: stay IDLE.

## Configuration
- `MANDEL_SCHED_TIMEOUT_EN` defined: a watchdog counts WAIT cycles. At `MAX_ITER+4` cycles without `eng_valid`, the block goes to WRITE with `pix_iter=MAX_ITER-1`, `pix_in_set=1`, and sets `timeout_err`. `timeout_err` clears only on `rst` or an accepted `frame_start`.
- Not defined: no watchdog; WAIT lasts until `eng_valid` or `abort`; `timeout_err` is tied to 0.

## Test plan
- Full frame: H_RES=4, V_RES=2, origin (-2.0, 1.0) in Q3.13 (0xC000, 0x2000), step 0x0800, stub engine returning iterations=x+y after 3 cycles → 8 writes in raster order; `c_re` sequence 0xC000, 0xC800, 0xD000, 0xD800, then 0xC000 with `c_im`=0x1800; `frame_done` one pulse.
- Back-pressure: `pix_ready` low for 5 cycles on pixel (2,0) → `pix_valid`, `pix_x=2`, `pix_iter` stable throughout; no `eng_start` until the handshake.
- Stale valid: stub holds `eng_valid=1` in the ISSUE cycle and the first WAIT cycle, then drops it for 2 cycles → no WRITE until the new assertion.
- Abort/reset: `abort` in WAIT of pixel (1,1) → IDLE next cycle, `busy=0`, no `frame_done`. Repeat with `rst` → all outputs 0.
- Ignored start and wrap: `frame_start` while busy → no effect. Origin 0x7F00, step 0x0200 → second pixel `c_re`=0x8100.
- Watchdog: with `MANDEL_SCHED_TIMEOUT_EN`, stub never asserts valid → WRITE after 260 WAIT cycles with `pix_iter`=255, `timeout_err`=1. Without the macro, the block stays in WAIT.

Source files
------------

// File: rtl/mandelbrot_scheduler.sv
// Frame sequencer for the mandelbrotetron engine: walks an H_RES x V_RES grid of c values,
// runs the engine once per pixel and streams each result out over valid/ready.
// Optional watchdog on the engine wait is enabled by defining MANDEL_SCHED_TIMEOUT_EN.
module mandelbrot_scheduler #(
  parameter  int FIXED_POINT_WIDTH = 16,
  parameter  int MAX_ITER          = 256,
  parameter  int H_RES             = 160,
  parameter  int V_RES             = 120,
  localparam int W                 = FIXED_POINT_WIDTH,
  localparam int IW                = $clog2(MAX_ITER),
  localparam int XW                = $clog2(H_RES),
  localparam int YW                = $clog2(V_RES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          abort,
  input  logic [W-1:0]  x_origin,
  input  logic [W-1:0]  y_origin,
  input  logic [W-1:0]  step,
  output logic          eng_start,
  output logic [W-1:0]  eng_c_real,
  output logic [W-1:0]  eng_c_imag,
  input  logic          eng_valid,
  input  logic          eng_is_mandelbrot,
  input  logic [IW-1:0] eng_iterations,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [IW-1:0] pix_iter,
  output logic          pix_in_set,
  output logic          busy,
  output logic          frame_done,
  output logic          timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

  state_t        state, state_d;
  logic [W-1:0]  c_re, c_im, x_org, step_r;
  logic          wait_first;
  logic          start_ok, take_result, handshake;
  logic          last_col, last_row;
  logic          timeout_hit, timed_out;

  assign last_col   = (pix_x == XW'(H_RES - 1));
  assign last_row   = (pix_y == YW'(V_RES - 1));

  assign eng_start  = (state == ISSUE);
  assign pix_valid  = (state == WRITE);
  assign busy       = (state != IDLE);
  assign eng_c_real = c_re;
  assign eng_c_imag = c_im;

  // NOTE: every output of this block is given a default before the case, so no latch is inferred.
  always_comb begin
    state_d     = state;
    start_ok    = 1'b0;
    take_result = 1'b0;
    handshake   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_d  = ISSUE;
          start_ok = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // The first WAIT cycle may still see the previous pixel's valid.
        if ((eng_valid && !wait_first) || timeout_hit) begin
          state_d     = WRITE;
          take_result = 1'b1;
        end
      end
      WRITE: begin
        if (pix_ready) begin
          handshake = 1'b1;
          state_d   = (last_col && last_row) ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      start_ok    = 1'b0;
      take_result = 1'b0;
      handshake   = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_x      <= '0;
      pix_y      <= '0;
      c_re       <= '0;
      c_im       <= '0;
      x_org      <= '0;
      step_r     <= '0;
      pix_iter   <= '0;
      pix_in_set <= 1'b0;
      wait_first <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wait_first <= (state == ISSUE);
      frame_done <= handshake && last_col && last_row;
      if (start_ok) begin
        x_org  <= x_origin;
        step_r <= step;
        pix_x  <= '0;
        pix_y  <= '0;
        c_re   <= x_origin;
        c_im   <= y_origin;
      end
      if (take_result) begin
        pix_iter   <= timed_out ? IW'(MAX_ITER - 1) : eng_iterations;
        pix_in_set <= timed_out ? 1'b1 : eng_is_mandelbrot;
      end
      if (handshake) begin
        if (!last_col) begin
          pix_x <= pix_x + XW'(1);
          c_re  <= c_re + step_r;
        end else if (!last_row) begin
          // Imaginary axis decreases going down the frame.
          pix_x <= '0;
          pix_y <= pix_y + YW'(1);
          c_re  <= x_org;
          c_im  <= c_im - step_r;
        end
      end
    end
  end

`ifdef MANDEL_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(MAX_ITER + 4);
  logic [CW-1:0] wd_cnt;
  logic          timeout_q;

  assign timeout_hit = (state == WAIT) && (wd_cnt == CW'(MAX_ITER + 3));
  assign timed_out   = timeout_hit && !(eng_valid && !wait_first);
  assign timeout_err = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT) ? wd_cnt + CW'(1) : '0;
      if (start_ok)                      timeout_q <= 1'b0;
      else if (take_result && timed_out) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mandelbrot_scheduler.sv
// Scoreboard bench for mandelbrot_scheduler on a 4x2 frame with a stub engine.
// Expected pixels are queued by the stimulus and popped by a monitor on each handshake.
module tb_mandelbrot_scheduler;
  localparam int HR = 4;
  localparam int VR = 2;

  logic        clk = 1'b0;
  logic        rst, frame_start, abort;
  logic [15:0] x_origin, y_origin, step;
  logic        eng_start, eng_valid, eng_is_mandelbrot;
  logic [15:0] eng_c_real, eng_c_imag;
  logic [7:0]  eng_iterations, pix_iter;
  logic        pix_valid, pix_ready, pix_in_set, busy, frame_done, timeout_err;
  logic [1:0]  pix_x;
  logic [0:0]  pix_y;

  mandelbrot_scheduler #(.FIXED_POINT_WIDTH(16), .MAX_ITER(256), .H_RES(HR), .V_RES(VR)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
    .x_origin(x_origin), .y_origin(y_origin), .step(step),
    .eng_start(eng_start), .eng_c_real(eng_c_real), .eng_c_imag(eng_c_imag),
    .eng_valid(eng_valid), .eng_is_mandelbrot(eng_is_mandelbrot), .eng_iterations(eng_iterations),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_iter(pix_iter), .pix_in_set(pix_in_set), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] re;
    logic [15:0] im;
    logic [7:0]  iter;
    logic        in_set;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Stub engine configuration, written only by the main sequence.
  int          stub_mode = 0;   // 0: latency 3, 1: stale valid, 2: never valid
  logic [15:0] sx0 = '0, sy0 = '0, sstep = 16'h1;
  logic        stall_en = 1'b0;

  // Hand-computed frame tables (raster order).
  localparam logic [15:0] F1_RE [8] = '{16'hC000, 16'hC800, 16'hD000, 16'hD800,
                                        16'hC000, 16'hC800, 16'hD000, 16'hD800};
  localparam logic [15:0] F1_IM [8] = '{16'h2000, 16'h2000, 16'h2000, 16'h2000,
                                        16'h1800, 16'h1800, 16'h1800, 16'h1800};
  localparam logic [15:0] F2_RE [8] = '{16'h7F00, 16'h8100, 16'h8300, 16'h8500,
                                        16'h7F00, 16'h8100, 16'h8300, 16'h8500};
  localparam logic [15:0] F2_IM [8] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100,
                                        16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
  localparam logic [7:0]  XY_IT [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_pix(input int k, input logic [15:0] re, input logic [15:0] im,
                          input logic [7:0] it, input logic ins);
    pix_t e;
    e.x = k % HR; e.y = k / HR; e.re = re; e.im = im; e.iter = it; e.in_set = ins;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every handshake against the head of the scoreboard.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pixel: got x=%0d y=%0d iter=%0d, expected none", pix_x, pix_y, pix_iter);
        end else begin
          e = exp_q.pop_front();
          check("pix_x", pix_x, e.x);
          check("pix_y", pix_y, e.y);
          check("c_real", eng_c_real, e.re);
          check("c_imag", eng_c_imag, e.im);
          check("pix_iter", pix_iter, e.iter);
          check("pix_in_set", pix_in_set, e.in_set);
        end
      end
    end
  end

  // Stub engine: result = x+y recovered from c, in_set = LSB of that.
  initial begin
    logic [15:0] dx, dy;
    logic [7:0]  it;
    eng_valid = 1'b0; eng_iterations = 8'h55; eng_is_mandelbrot = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (eng_start && stub_mode != 2) begin
        dx = eng_c_real - sx0;
        dy = sy0 - eng_c_imag;
        it = 8'((dx / sstep) + (dy / sstep));
        if (stub_mode == 0) begin
          repeat (3) begin @(posedge clk); #1; end
          eng_valid = 1'b1; eng_iterations = it; eng_is_mandelbrot = it[0];
          @(posedge clk); #1;
          eng_valid = 1'b0; eng_iterations = 8'h55; eng_is_mandelbrot = ~it[0];
        end else begin
          eng_valid = 1'b1; eng_iterations = 8'hEE; eng_is_mandelbrot = ~it[0];
          @(posedge clk); #1;
          @(posedge clk); #1;
          eng_valid = 1'b0;
          check("stale_wait2_no_write", pix_valid, 1'b0);
          @(posedge clk); #1;
          check("stale_wait3_no_write", pix_valid, 1'b0);
          @(posedge clk); #1;
          check("stale_wait4_no_write", pix_valid, 1'b0);
          eng_valid = 1'b1; eng_iterations = it; eng_is_mandelbrot = it[0];
          @(posedge clk); #1;
          eng_valid = 1'b0; eng_iterations = 8'h55; eng_is_mandelbrot = ~it[0];
        end
      end
    end
  end

  // Downstream: always ready, except a 5-cycle stall on pixel (2,0) when enabled.
  initial begin
    int held = 0;
    pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!stall_en) held = 0;
      if (stall_en && held > 0 && held < 5) begin
        pix_ready = 1'b0;
        check("bp_valid", pix_valid, 1'b1);
        check("bp_x", pix_x, 2);
        check("bp_y", pix_y, 0);
        check("bp_iter", pix_iter, 8'd2);
        check("bp_no_start", eng_start, 1'b0);
        held++;
      end else if (stall_en && held == 0 && pix_valid && pix_x == 2'd2 && pix_y == 1'b0) begin
        pix_ready = 1'b0;
        held = 1;
      end else begin
        pix_ready = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_frame(input logic [15:0] xo, input logic [15:0] yo, input logic [15:0] st);
    x_origin = xo; y_origin = yo; step = st;
    sx0 = xo; sy0 = yo; sstep = st;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_eng_start", eng_start, 1'b1);
    check("start_c_real", eng_c_real, xo);
    check("start_c_imag", eng_c_imag, yo);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!frame_done && n < budget) begin tick(1); n++; end
    check({name, "_frame_done"}, frame_done, 1'b1);
    check({name, "_done_busy"}, busy, 1'b0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    tick(1);
    check({name, "_done_one_cycle"}, frame_done, 1'b0);
  endtask

  task automatic wait_pixel_1_1(input string name);
    int n = 0;
    while (!(busy && !eng_start && !pix_valid && eng_c_real == 16'hC800 && eng_c_imag == 16'h1800)
           && n < 400) begin
      tick(1); n++;
    end
    check({name, "_reached_wait_1_1"}, (n < 400), 1'b1);
  endtask

  task automatic watch_no_done(input string name, input int n);
    logic seen = 1'b0;
    repeat (n) begin tick(1); if (frame_done) seen = 1'b1; end
    check({name, "_no_frame_done"}, seen, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; frame_start = 1'b0; abort = 1'b0;
    x_origin = '0; y_origin = '0; step = '0;
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_outputs", {pix_x, pix_y, pix_iter, pix_in_set}, 0);
    check("rst_c", {eng_c_real, eng_c_imag}, 0);
    rst = 1'b0;
    tick(2);

    // Full frame with back-pressure on (2,0) and an ignored mid-frame start.
    stub_mode = 0; stall_en = 1'b1;
    for (int k = 0; k < 8; k++) push_pix(k, F1_RE[k], F1_IM[k], XY_IT[k], XY_IT[k][0]);
    start_frame(16'hC000, 16'h2000, 16'h0800);
    tick(10);
    x_origin = 16'h1234; y_origin = 16'h4321; step = 16'h0001;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("ignored_start_busy", busy, 1'b1);
    wait_done("f1", 500);
    stall_en = 1'b0;
    tick(3);

    // Stale valid on every pixel, plus two's-complement wrap of c.
    stub_mode = 1;
    for (int k = 0; k < 8; k++) push_pix(k, F2_RE[k], F2_IM[k], XY_IT[k], XY_IT[k][0]);
    start_frame(16'h7F00, 16'h0100, 16'h0200);
    wait_done("f2", 500);
    tick(3);

    // Abort in WAIT of pixel (1,1).
    stub_mode = 0;
    for (int k = 0; k < 5; k++) push_pix(k, F1_RE[k], F1_IM[k], XY_IT[k], XY_IT[k][0]);
    start_frame(16'hC000, 16'h2000, 16'h0800);
    wait_pixel_1_1("abort");
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_pix_valid", pix_valid, 1'b0);
    check("abort_eng_start", eng_start, 1'b0);
    watch_no_done("abort", 10);
    check("abort_queue_empty", exp_q.size(), 0);

    // Abort together with frame_start in IDLE: stays idle.
    frame_start = 1'b1; abort = 1'b1;
    tick(1);
    frame_start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 1'b0);
    check("abort_start_eng_start", eng_start, 1'b0);
    tick(2);

    // Reset in WAIT of pixel (1,1).
    for (int k = 0; k < 5; k++) push_pix(k, F1_RE[k], F1_IM[k], XY_IT[k], XY_IT[k][0]);
    start_frame(16'hC000, 16'h2000, 16'h0800);
    wait_pixel_1_1("reset");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_flags", {busy, eng_start, pix_valid, frame_done, timeout_err}, 0);
    check("mid_rst_outputs", {pix_x, pix_y, pix_iter, pix_in_set}, 0);
    check("mid_rst_c", {eng_c_real, eng_c_imag}, 0);
    watch_no_done("reset", 10);
    check("reset_queue_empty", exp_q.size(), 0);

    // Engine that never answers.
    stub_mode = 2;
`ifdef MANDEL_SCHED_TIMEOUT_EN
    push_pix(0, 16'hC000, 16'h2000, 8'hFF, 1'b1);
`endif
    start_frame(16'hC000, 16'h2000, 16'h0800);
    n = 0;
    while (!pix_valid && n < 400) begin tick(1); n++; end
`ifdef MANDEL_SCHED_TIMEOUT_EN
    check("wd_write_cycle", n, 261);
    check("wd_timeout_err", timeout_err, 1'b1);
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("wd_err_sticky", timeout_err, 1'b1);
    start_frame(16'hC000, 16'h2000, 16'h0800);
    check("wd_err_cleared", timeout_err, 1'b0);
`else
    check("no_wd_still_waiting", pix_valid, 1'b0);
    check("no_wd_busy", busy, 1'b1);
    check("no_wd_err", timeout_err, 1'b0);
`endif
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("final_idle", busy, 1'b0);
    tick(3);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
